// File: rtl/seq_div.sv
// ----------------------------------------------------------------------------
// seq_div -- sequential signed divider, 16-bit dividend by 8-bit divisor.
//
// Restoring division on operand magnitudes, one quotient bit per clock, MSB
// first, followed by a single sign-fix cycle. The result is truncated toward
// zero: the remainder takes the sign of the dividend. A zero divisor skips
// the datapath and reports div_by_zero. -32768 / -1 saturates the quotient
// to 32767 and reports overflow.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active high
//   in_valid     in   operand pair valid
//   in_ready     out  block idle, can accept an operand pair
//   dividend     in   [15:0] signed dividend
//   divisor      in   [7:0]  signed divisor
//   out_valid    out  result valid (held until out_ready)
//   out_ready    in   consumer takes the result
//   quotient     out  [15:0] signed quotient
//   remainder    out  [7:0]  signed remainder
//   div_by_zero  out  result flag: divisor was zero
//   overflow     out  result flag: quotient saturated
// ----------------------------------------------------------------------------
module seq_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;          // iteration counter, 0..15
    logic [15:0] dvd_q, dvd_d;          // dividend bits shift out, quotient bits shift in
    logic [8:0]  dsr_q, dsr_d;          // divisor magnitude
    logic [8:0]  rem_q, rem_d;          // partial remainder magnitude
    logic        dvd_neg_q, dvd_neg_d;
    logic        dsr_neg_q, dsr_neg_d;
    logic [15:0] quo_q, quo_d;
    logic [7:0]  rmd_q, rmd_d;
    logic        dz_q, dz_d;
    logic        ov_q, ov_d;

    // Magnitudes carry one extra bit so |-32768| and |-128| are exact.
    logic [16:0] dvd_ext, dvd_mag;
    logic [8:0]  dsr_ext, dsr_mag;

    always_comb begin
        dvd_ext = {dividend[15], dividend};
        dsr_ext = {divisor[7], divisor};
        dvd_mag = dividend[15] ? (~dvd_ext + 17'd1) : dvd_ext;
        dsr_mag = divisor[7]   ? (~dsr_ext + 9'd1)  : dsr_ext;
    end

    // One restoring step: bring down the next dividend bit and subtract the
    // divisor if it fits. The partial remainder stays below the divisor
    // (<= 128), so the trial value fits in 9 bits and the difference taken
    // when it fits is below the divisor again.
    logic [9:0] trial;
    logic       fits;
    logic [8:0] diff;

    always_comb begin
        trial = {rem_q, dvd_q[15]};
        fits  = (trial >= {1'b0, dsr_q});
        diff  = trial[8:0] - dsr_q;
    end

    // Sign fix. Only a non-negative result can exceed 32767, and only
    // |-32768| / 1 reaches 32768, so bit 15 of a positive magnitude
    // is exactly the saturation condition.
    logic        res_neg;
    logic        sat;
    logic [15:0] quo_fixed;
    logic [7:0]  rmd_fixed;

    always_comb begin
        res_neg   = dvd_neg_q ^ dsr_neg_q;
        sat       = !res_neg && dvd_q[15];
        quo_fixed = sat     ? 16'h7FFF : (res_neg ? (~dvd_q + 16'd1) : dvd_q);
        rmd_fixed = dvd_neg_q ? (~rem_q[7:0] + 8'd1) : rem_q[7:0];
    end

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            dvd_q     <= 16'd0;
            dsr_q     <= 9'd0;
            rem_q     <= 9'd0;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            quo_q     <= 16'd0;
            rmd_q     <= 8'd0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            dvd_neg_q <= dvd_neg_d;
            dsr_neg_q <= dsr_neg_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        dvd_neg_d = dvd_neg_q;
        dsr_neg_d = dsr_neg_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dz_d      = dz_q;
        ov_d      = ov_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == 8'd0) begin
                        quo_d   = 16'd0;
                        rmd_d   = 8'd0;
                        dz_d    = 1'b1;
                        ov_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        // Bit 16 of the dividend magnitude is always 0; seeding
                        // it into the partial remainder keeps the full 17-bit
                        // magnitude in the datapath without a 17th iteration.
                        dvd_d     = dvd_mag[15:0];
                        rem_d     = {8'd0, dvd_mag[16]};
                        dsr_d     = dsr_mag;
                        dvd_neg_d = dividend[15];
                        dsr_neg_d = divisor[7];
                        cnt_d     = 4'd0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = fits ? diff : trial[8:0];
                dvd_d = {dvd_q[14:0], fits};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = quo_fixed;
                rmd_d   = rmd_fixed;
                dz_d    = 1'b0;
                ov_d    = sat;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = 16'd0;
    logic [7:0]  divisor = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    seq_div dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Drive one operand pair through its accept edge; returns 1 us after it.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges waited until out_valid, or -1 if the bound runs out.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 ||
            remainder !== 8'd0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b q=%h r=%h dz=%b ov=%b, want 1 0 0000 00 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'd1000, 8'd7);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: in_ready=%b, want 0", in_ready);
        end
        wait_out(lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL basic_latency: out_valid on edge %0d after accept, want 18", lat + 1);
        end
        checks++;
        if (quotient !== 16'd142 || remainder !== 8'd6 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d dz=%b ov=%b, want 142 6 0 0",
                     $signed(quotient), $signed(remainder), div_by_zero, overflow);
        end
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_signs();
        logic signed [15:0] a  [4] = '{-16'sd1000, 16'sd1000, -16'sd1000, 16'sd32767};
        logic signed [7:0]  b  [4] = '{8'sd7, -8'sd7, -8'sd7, -8'sd128};
        logic signed [15:0] eq [4] = '{-16'sd142, -16'sd142, 16'sd142, -16'sd255};
        logic signed [7:0]  er [4] = '{-8'sd6, 8'sd6, -8'sd6, 8'sd127};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(a[i], b[i]);
            wait_out(lat);
            checks++;
            if (lat !== 17 || quotient !== eq[i] || remainder !== er[i] ||
                div_by_zero !== 1'b0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL signs[%0d] %0d/%0d: lat=%0d q=%0d r=%0d dz=%b ov=%b, want lat=17 q=%0d r=%0d 0 0",
                         i, a[i], b[i], lat, $signed(quotient), $signed(remainder),
                         div_by_zero, overflow, eq[i], er[i]);
            end
            release_out();
        end
    endtask

    task automatic test_overflow();
        int lat;
        start_op(16'h8000, 8'hFF);
        wait_out(lat);
        checks++;
        if (lat !== 17 || quotient !== 16'h7FFF || remainder !== 8'd0 ||
            overflow !== 1'b1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sat: lat=%0d q=%h r=%h ov=%b dz=%b, want 17 7fff 00 1 0",
                     lat, quotient, remainder, overflow, div_by_zero);
        end
        release_out();
        start_op(16'h8000, 8'h01);
        wait_out(lat);
        checks++;
        if (lat !== 17 || quotient !== 16'h8000 || remainder !== 8'd0 ||
            overflow !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ovf_min_by_one: lat=%0d q=%h r=%h ov=%b dz=%b, want 17 8000 00 0 0",
                     lat, quotient, remainder, overflow, div_by_zero);
        end
        release_out();
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(16'd5, 8'd0);
        checks++;
        if (out_valid !== 1'b1 || quotient !== 16'd0 || remainder !== 8'd0 ||
            div_by_zero !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL div0: vld=%b q=%h r=%h dz=%b ov=%b on 1st edge, want 1 0000 00 1 0",
                     out_valid, quotient, remainder, div_by_zero, overflow);
        end
        release_out();
        start_op(16'd100, 8'd3);
        wait_out(lat);
        checks++;
        if (lat !== 17 || quotient !== 16'd33 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL div0_clear: lat=%0d q=%0d r=%0d dz=%b, want 17 33 1 0",
                     lat, quotient, remainder, div_by_zero);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        logic [15:0] hq;
        logic [7:0]  hr;
        start_op(16'd1000, 8'hF9);          // 1000 / -7
        bad = 0;
        for (int i = 0; i < 8; i++) begin   // noise on the inputs during CALC
            in_valid = ~in_valid;
            dividend = 16'(i * 77 + 3);
            divisor  = 8'(i);
            @(posedge clk); #1;
            if (in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL calc_ignore_ready: in_ready high %0d times during CALC, want 0", bad);
        end
        wait_out(lat);
        checks++;
        if (lat + 8 !== 17 || quotient !== 16'hFF72 || remainder !== 8'd6) begin
            errors++;
            $display("FAIL calc_ignore_result: lat=%0d q=%0d r=%0d, want 17 -142 6",
                     lat + 8, $signed(quotient), $signed(remainder));
        end
        hq  = quotient;
        hr  = remainder;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'd999;
            divisor  = 8'd9;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== hq ||
                remainder !== hr || div_by_zero !== 1'b0 || overflow !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles, want 0 (q=%h r=%h)",
                     bad, quotient, remainder);
        end
        // Release with in_valid still high: the release edge must not accept.
        dividend  = 16'd100;
        divisor   = 8'd3;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_no_accept: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;                 // earliest next accept
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL next_accept: in_ready=%b, want 0", in_ready);
        end
        wait_out(lat);
        checks++;
        if (lat !== 17 || quotient !== 16'd33 || remainder !== 8'd1) begin
            errors++;
            $display("FAIL next_result: lat=%0d q=%0d r=%0d, want 17 33 1", lat, quotient, remainder);
        end
        release_out();
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int bad;
        start_op(16'd1000, 8'd7);
        repeat (8) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b vld=%b q=%h r=%h, want 1 0 0000 00",
                     in_ready, out_valid, quotient, remainder);
        end
        @(negedge clk); rst = 1'b0;
        bad = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_discard: %0d cycles with out_valid or !in_ready, want 0", bad);
        end
        start_op(16'd100, 8'd3);
        wait_out(lat);
        checks++;
        if (lat !== 17 || quotient !== 16'd33 || remainder !== 8'd1 ||
            div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: lat=%0d q=%0d r=%0d dz=%b ov=%b, want 17 33 1 0 0",
                     lat, quotient, remainder, div_by_zero, overflow);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  dividend/divisor valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 dividend  input  16  signed two's-complement dividend.
REQ-007 divisor  input  8  signed two's-complement divisor.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 quotient  output  16  signed quotient.
REQ-011 remainder  output  8  signed remainder.
REQ-012 div_by_zero  output  1  result flag: divisor was 0.
REQ-013 overflow  output  1  result flag: quotient saturated.

Function
REQ-014 Accept occurs on a rising edge where in_valid=1 and in_ready=1; dividend and divisor SHALL be captured only at accept.
REQ-015 FSM states: IDLE, CALC, FIX, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE->CALC on accept with divisor!=0; IDLE->DONE on accept with divisor==0.
REQ-017 CALC: restoring division on magnitudes, one quotient bit per cycle, MSB first, exactly 16 cycles, then ->FIX.
REQ-018 Magnitudes use 17-bit (dividend) and 9-bit (divisor) internal widths so |-32768| and |-128| are exact.
REQ-019 FIX, one cycle: quotient negated if operand signs differ; remainder takes the dividend's sign (truncation toward zero); then ->DONE.
REQ-020 Normal-case latency: out_valid rises on the 18th rising edge after the accept edge.
REQ-021 Invariant: dividend == quotient*divisor + remainder, and |remainder| < |divisor|.
REQ-022 Overflow (dividend=-32768, divisor=-1): quotient=16'sh7FFF, remainder=0, overflow=1.
REQ-023 Divide by zero: quotient=0, remainder=0, div_by_zero=1, overflow=0; out_valid rises on the 1st edge after accept.
REQ-024 DONE: quotient, remainder and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 DONE->IDLE on an edge with out_ready=1; no accept on that same edge because in_ready=0 in DONE.
REQ-026 The earliest next accept is the edge after returning to IDLE.
REQ-027 Input changes while not in IDLE SHALL have no effect.
REQ-028 Flags SHALL be 0 on normal results and SHALL be updated with every result.

Reset
REQ-029 rst=1 SHALL force IDLE immediately, regardless of clk.
REQ-030 Reset values: in_ready=1 (combinational from IDLE), out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, iteration counter=0.
REQ-031 Reset asserted mid-CALC or in DONE SHALL discard the operation; no out_valid follows reset release.

Verification
REQ-032 1000/7 -> quotient=142, remainder=6, flags 0, out_valid on the 18th edge after accept.
REQ-033 Sign matrix: -1000/7 -> -142,-6; 1000/-7 -> -142,6; -1000/-7 -> 142,-6; also 32767/-128 -> -255,127.
REQ-034 -32768/-1 -> quotient=32767, remainder=0, overflow=1; -32768/1 -> -32768, 0, overflow=0.
REQ-035 5/0 -> quotient=0, remainder=0, div_by_zero=1, out_valid on the 1st edge after accept; the next result's div_by_zero returns to 0.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; toggling in_valid during CALC is ignored.
REQ-037 Assert rst at CALC iteration 8 -> immediate IDLE and out_valid=0; a subsequent 100/3 -> 33, 1.
